// File: rtl/sram_like_arbiter_pkg.sv
// Purpose : shared state/owner/size encodings for the sram-like arbiter slice.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package sram_like_arbiter_pkg;

    // Arbiter FSM encoding: one transaction in flight at most.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arbState_t;

    // Transaction owner: which requester the bus currently works for.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Transfer size codes carried on *_size.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_rr_grant2.sv
// Purpose : 2-way round-robin grant (req0 = fetch, req1 = MEM data) with last-owner memory.
// Latency : grant is combinational; lastOwner updates one cycle after update=1.
// Backpressure: grant is only a proposal; it is consumed only when update is asserted.
//
// Ports: clock/reset (sync, active-high); req0/req1 requests; update commits the
// current grant into lastOwner; grantValid/grantOwner give the proposed winner.
module rr_grant2
    import sram_like_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic grantValid,
    output logic grantOwner
);

    logic lastOwner;

    // On a tie the requester that did not win last time gets the bus. Since
    // lastOwner resets to the fetch side, the data side wins the first tie.
    always_comb begin
        grantValid = req0 | req1;
        grantOwner = OWN_INST;
        if (req0 && req1) begin
            grantOwner = ~lastOwner;
        end else if (req1) begin
            grantOwner = OWN_DATA;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastOwner <= OWN_INST;
        end else if (update) begin
            lastOwner <= grantOwner;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Purpose : shares one sram-like master port between fetch (inst_*) and MEM (data_*) requesters.
// Latency : request seen in cycle N drives bus_req in N+1; addr_ok/data_ok forwarded combinationally.
// Backpressure: requester holds req until its addr_ok; one outstanding transaction, no new grant until back in IDLE.
//
// Ports: inst_* / data_* requester sides (req, wr, size, addr, wdata in; addr_ok,
// data_ok, rdata out); bus_* master side toward the AXI bridge; busy is high
// while a transaction is in flight.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              busy
);

    arbState_t         state;
    arbState_t         stateNext;

    logic              ownerQ;
    logic              wrQ;
    logic [1:0]        sizeQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;

    logic              grantValid;
    logic              grantOwner;
    logic              grantTake;

    logic              reqPhase;
    logic              addrHs;
    logic              dataHs;

    // Grants are only taken from IDLE, so a completion cycle can never overlap
    // a new grant: the next owner is chosen the cycle after returning to IDLE.
    assign grantTake = (state == IDLE) && grantValid;

    rr_grant2 uGrant (
        .clock      (clock),
        .reset      (reset),
        .req0       (inst_req),
        .req1       (data_req),
        .update     (grantTake),
        .grantValid (grantValid),
        .grantOwner (grantOwner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ownerQ <= OWN_INST;
            wrQ    <= 1'b0;
            sizeQ  <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else begin
            state <= stateNext;
            if (grantTake) begin
                ownerQ <= grantOwner;
                if (grantOwner == OWN_DATA) begin
                    wrQ    <= data_wr;
                    sizeQ  <= data_size;
                    addrQ  <= data_addr;
                    wdataQ <= data_wdata;
                end else begin
                    wrQ    <= inst_wr;
                    sizeQ  <= inst_size;
                    addrQ  <= inst_addr;
                    wdataQ <= inst_wdata;
                end
            end
        end
    end

    // Handshakes are only honoured in ADDR/WAIT; anything the slave signals in
    // IDLE is stray and dropped here. Once latched, a transaction runs to
    // completion even if its requester withdraws req.
    always_comb begin
        stateNext = state;
        reqPhase  = 1'b0;
        addrHs    = 1'b0;
        dataHs    = 1'b0;
        case (state)
            IDLE: begin
                if (grantValid) begin
                    stateNext = ADDR;
                end
            end
            ADDR: begin
                reqPhase = 1'b1;
                if (bus_addr_ok) begin
                    addrHs = 1'b1;
                    if (bus_data_ok) begin
                        dataHs    = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    dataHs    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Reset is synchronous, so state may still be ADDR/WAIT during the reset
    // cycle; the strobes are masked so nothing leaks out while reset is high.
    assign bus_req      = reqPhase && !reset;
    assign busy         = (state != IDLE) && !reset;
    assign bus_wr       = wrQ;
    assign bus_size     = sizeQ;
    assign bus_addr     = addrQ;
    assign bus_wdata    = wdataQ;

    assign inst_addr_ok = addrHs && !reset && (ownerQ == OWN_INST);
    assign inst_data_ok = dataHs && !reset && (ownerQ == OWN_INST);
    assign data_addr_ok = addrHs && !reset && (ownerQ == OWN_DATA);
    assign data_data_ok = dataHs && !reset && (ownerQ == OWN_DATA);

    // Read data is shared; each side qualifies it with its own data_ok.
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Purpose : directed self-checking bench for sram_like_arbiter with a transaction-level reference model.
// Latency : inputs change 1 time unit after posedge; outputs compared on negedge.
// Backpressure: the bench plays both requesters and the slave.
module tb_sram_like_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;

    logic          inst_req, inst_wr;
    logic [1:0]    inst_size;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_wdata;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;

    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;

    logic          bus_req, bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok, bus_data_ok;
    logic [DW-1:0] bus_rdata;
    logic          busy;

    int nVec = 0;
    int nErr = 0;
    bit checkOn = 1'b0;

    sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // One transaction record: is one in flight, has its address been accepted,
    // whose is it and what does it carry. mLast = requester granted last.
    bit          mBusy     = 1'b0;
    bit          mAccepted = 1'b0;
    bit          mOwner    = 1'b0;
    bit          mLast     = 1'b0;
    bit          mWr       = 1'b0;
    logic [1:0]  mSize     = '0;
    logic [31:0] mAddr     = '0;
    logic [31:0] mWdata    = '0;

    always @(posedge clock) begin
        if (reset) begin
            mBusy = 0; mAccepted = 0; mOwner = 0; mLast = 0;
            mWr = 0; mSize = '0; mAddr = '0; mWdata = '0;
        end else if (!mBusy) begin
            if (inst_req || data_req) begin
                bit pick;
                if (inst_req && data_req) pick = !mLast;   // whoever did not go last
                else                      pick = data_req;
                mBusy = 1; mAccepted = 0; mOwner = pick; mLast = pick;
                mWr    = pick ? data_wr    : inst_wr;
                mSize  = pick ? data_size  : inst_size;
                mAddr  = pick ? data_addr  : inst_addr;
                mWdata = pick ? data_wdata : inst_wdata;
            end
        end else if (bus_data_ok && (mAccepted || bus_addr_ok)) begin
            mBusy = 0;
        end else if (bus_addr_ok) begin
            mAccepted = 1;
        end
    end

    always @(negedge clock) begin
        if (checkOn) begin
            bit expReq, expAok, expDok;
            expReq = !reset && mBusy && !mAccepted;
            expAok = expReq && bus_addr_ok;
            expDok = !reset && mBusy && (mAccepted || bus_addr_ok) && bus_data_ok;
            chk("bus_req",      bus_req,      expReq);
            chk("busy",         busy,         !reset && mBusy);
            chk("bus_wr",       bus_wr,       mWr);
            chk("bus_size",     bus_size,     mSize);
            chk("bus_addr",     bus_addr,     mAddr);
            chk("bus_wdata",    bus_wdata,    mWdata);
            chk("inst_addr_ok", inst_addr_ok, expAok && !mOwner);
            chk("data_addr_ok", data_addr_ok, expAok && mOwner);
            chk("inst_data_ok", inst_data_ok, expDok && !mOwner);
            chk("data_data_ok", data_data_ok, expDok && mOwner);
            if (expDok && !mOwner) chk("inst_rdata", inst_rdata, bus_rdata);
            if (expDok && mOwner)  chk("data_rdata", data_rdata, bus_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clearIn();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] expOrder [4];
        expOrder[0] = 32'h8000_0020; expOrder[1] = 32'hBFC0_0010;
        expOrder[2] = 32'h8000_0020; expOrder[3] = 32'hBFC0_0010;

        clearIn();
        reset = 1;
        tick(); tick();
        checkOn = 1;
        settle();
        chk("rst bus_req", bus_req, 0);
        chk("rst busy", busy, 0);
        chk("rst bus_addr", bus_addr, 0);

        // ---- single fetch ----
        tick(); reset = 0;
        inst_req = 1; inst_addr = 32'hBFC0_0000;                  // cycle 0
        settle(); chk("f0 bus_req", bus_req, 0);
        tick(); settle();                                          // cycle 1
        chk("f1 bus_req", bus_req, 1);
        chk("f1 bus_addr", bus_addr, 32'hBFC0_0000);
        tick(); bus_addr_ok = 1; settle();                         // cycle 2
        chk("f2 bus_req", bus_req, 1);
        chk("f2 inst_addr_ok", inst_addr_ok, 1);
        tick(); bus_addr_ok = 0; inst_req = 0; settle();           // cycle 3
        chk("f3 bus_req", bus_req, 0);
        tick(); bus_data_ok = 1; bus_rdata = 32'h3C08_0001; settle(); // cycle 4
        chk("f4 inst_data_ok", inst_data_ok, 1);
        chk("f4 inst_rdata", inst_rdata, 32'h3C08_0001);
        chk("f4 data_data_ok", data_data_ok, 0);
        tick(); bus_data_ok = 0; settle();
        chk("f5 busy", busy, 0);

        // ---- simultaneous requests after reset, alternation, same-cycle handshake ----
        reset = 1; tick(); reset = 0;
        inst_req = 1; inst_addr = 32'hBFC0_0010;
        data_req = 1; data_addr = 32'h8000_0020;
        for (int t = 0; t < 4; t++) begin
            int bound;
            bound = 0;
            settle();
            while (!bus_req && bound < 8) begin
                tick(); settle(); bound++;
            end
            if (bound == 8) begin
                chk("rr grant timeout", 0, 1);
            end else begin
                chk("rr order addr", bus_addr, expOrder[t]);
                #1; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hA000_0000 + t;
                settle();
                chk("rr addr_ok", (t % 2 == 0) ? data_addr_ok : inst_addr_ok, 1);
                chk("rr data_ok", (t % 2 == 0) ? data_data_ok : inst_data_ok, 1);
                tick(); bus_addr_ok = 0; bus_data_ok = 0; settle();
                chk("rr busy fell", busy, 0);
            end
        end
        clearIn();
        tick();

        // ---- data write ----
        data_req = 1; data_wr = 1; data_size = 2'd2;
        data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
        tick(); settle();
        chk("w bus_wr", bus_wr, 1);
        chk("w bus_wdata", bus_wdata, 32'h1234_5678);
        chk("w bus_size", bus_size, 2);
        tick(); bus_addr_ok = 1; settle();
        chk("w data_addr_ok", data_addr_ok, 1);
        tick(); bus_addr_ok = 0; data_req = 0; settle();
        tick(); bus_data_ok = 1; settle();
        chk("w data_data_ok", data_data_ok, 1);
        chk("w inst_data_ok", inst_data_ok, 0);
        tick(); clearIn();

        // ---- requester drops req after grant ----
        data_req = 1; data_addr = 32'h8000_0040;
        tick(); data_req = 0; settle();
        chk("d bus_req a", bus_req, 1);
        tick(); settle();
        chk("d bus_req b", bus_req, 1);
        tick(); bus_addr_ok = 1; settle();
        chk("d data_addr_ok", data_addr_ok, 1);
        tick(); bus_addr_ok = 0; settle();
        tick(); bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D; settle();
        chk("d data_data_ok", data_data_ok, 1);
        chk("d data_rdata", data_rdata, 32'hCAFE_F00D);
        tick(); clearIn();

        // ---- reset in WAIT, stray data_ok afterwards ----
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        tick(); bus_addr_ok = 1; inst_req = 0;
        tick(); bus_addr_ok = 0; settle();
        chk("r wait busy", busy, 1);
        reset = 1; settle();
        chk("r in-reset busy", busy, 0);
        tick(); reset = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF; settle();
        chk("r stray inst_data_ok", inst_data_ok, 0);
        chk("r stray data_data_ok", data_data_ok, 0);
        chk("r busy", busy, 0);
        chk("r bus_req", bus_req, 0);
        tick(); clearIn();

        // tie right after that reset: data must win again
        inst_req = 1; inst_addr = 32'hBFC0_0200;
        data_req = 1; data_addr = 32'h8000_0200;
        tick(); settle();
        chk("r tie bus_addr", bus_addr, 32'h8000_0200);
        tick(); bus_addr_ok = 1; bus_data_ok = 1; data_req = 0; inst_req = 0;
        tick(); clearIn();
        tick(); tick();

        checkOn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
